// File: rtl/freq_meter_if.sv
// Measurement bus of the gated frequency counter: enable and signal in,
// published count, status flags out.
interface freq_meter_if #(
  parameter int CNT_W = 32
) ();
  logic             en_i;
  logic             sig_i;
  logic [CNT_W-1:0] freq_o;
  logic             valid_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (
    output en_i, sig_i,
    input  freq_o, valid_o, ovf_o, busy_o
  );

  modport slave (
    input  en_i, sig_i,
    output freq_o, valid_o, ovf_o, busy_o
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_i over
// GATE_CYCLES clocks and publishes the count with a one-cycle valid pulse.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  freq_meter_if.slave bus
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [GW-1:0]    r_gate_ctr, w_gate_nxt;
  logic [CNT_W-1:0] r_edge_ctr, w_edge_nxt;
  logic             r_sat, w_sat_nxt;
  logic [CNT_W-1:0] r_freq, w_freq_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_valid, w_valid_nxt;

  logic             w_rise;
  logic             w_at_max;
  logic [CNT_W-1:0] w_edge_inc;
  logic             w_sat_inc;

  // s3 runs in every state, so a level already high when a gate opens is
  // not mistaken for an edge.
  assign w_rise     = r_s2 & ~r_s3;
  assign w_at_max   = &r_edge_ctr;
  assign w_edge_inc = (w_rise && !w_at_max) ? r_edge_ctr + CNT_W'(1) : r_edge_ctr;
  assign w_sat_inc  = r_sat | (w_rise & w_at_max);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = '0;
    w_edge_nxt  = '0;
    w_sat_nxt   = 1'b0;
    w_freq_nxt  = r_freq;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.en_i) w_state_nxt = GATE;
      end
      GATE: begin
        if (r_gate_ctr == LAST) begin
          // A rise in the final cycle still belongs to this gate.
          w_freq_nxt  = w_edge_inc;
          w_ovf_nxt   = w_sat_inc;
          w_valid_nxt = 1'b1;
          w_state_nxt = bus.en_i ? GATE : IDLE;
        end else if (!bus.en_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_gate_nxt = r_gate_ctr + GW'(1);
          w_edge_nxt = w_edge_inc;
          w_sat_nxt  = w_sat_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_gate_ctr <= '0;
      r_edge_ctr <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_s1       <= bus.sig_i;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_gate_ctr <= w_gate_nxt;
      r_edge_ctr <= w_edge_nxt;
      r_sat      <= w_sat_nxt;
      r_freq     <= w_freq_nxt;
      r_ovf      <= w_ovf_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign bus.freq_o  = r_freq;
  assign bus.ovf_o   = r_ovf;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = (r_state == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: expected gate results are queued as the
// stimulus is set up and compared whenever valid_o pulses.
module tb_freq_meter;

  localparam int G  = 100;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] freq;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(CW)) bus ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_valid  = 0;
  int   gen_period = 2;
  logic gen_level  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.valid_o !== 1'b1 && n < limit);
    if (bus.valid_o !== 1'b1) check("valid_timeout", {31'd0, bus.valid_o}, 1);
  endtask

  // Signal generator: periodic square wave, or a static level when period < 2.
  // Updates land 1 time unit after the falling edge so main-flow changes
  // made on that edge take effect deterministically.
  initial begin
    int cnt;
    cnt = 0;
    bus.sig_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (gen_period < 2) begin
        bus.sig_i = gen_level;
      end else begin
        cnt = (cnt + 1) % gen_period;
        bus.sig_i = (cnt < gen_period / 2);
      end
    end
  end

  // Output monitor: every valid pulse pops one expected result.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        n_valid++;
        check("valid_width", {31'd0, prev}, 0);
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, bus.valid_o}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("freq", {28'd0, bus.freq_o}, {28'd0, e.freq});
          check("ovf", {31'd0, bus.ovf_o}, {31'd0, e.ovf});
        end
      end
      prev = bus.valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int v0;

    // Reset with sig toggling and enable high
    rst_n      = 1'b0;
    bus.en_i   = 1'b1;
    gen_period = 2;
    tick(3);
    check("reset_freq",  {28'd0, bus.freq_o},  0);
    check("reset_valid", {31'd0, bus.valid_o}, 0);
    check("reset_ovf",   {31'd0, bus.ovf_o},   0);
    check("reset_busy",  {31'd0, bus.busy_o},  0);

    // Saturation: period 2 gives ~50 edges into a 4-bit counter
    sb.push_back(exp_t'{freq: 4'd15, ovf: 1'b1});
    rst_n = 1'b1;
    tick(1);
    check("busy_after_reset", {31'd0, bus.busy_o}, 1);
    wait_valid(150, n);
    bus.en_i = 1'b0;
    tick(2);
    check("abort_idle", {31'd0, bus.busy_o}, 0);

    // Overflow clears on the next unsaturated gate
    gen_period = 20;
    tick(8);
    sb.push_back(exp_t'{freq: 4'd5, ovf: 1'b0});
    bus.en_i = 1'b1;
    wait_valid(150, n);
    bus.en_i = 1'b0;
    tick(2);

    // Continuous back-to-back gates with period 10
    gen_period = 10;
    tick(8);
    repeat (3) sb.push_back(exp_t'{freq: 4'd10, ovf: 1'b0});
    bus.en_i = 1'b1;
    wait_valid(150, n);
    wait_valid(150, n);
    check("valid_period1", n, G);
    check("busy_cont", {31'd0, bus.busy_o}, 1);
    wait_valid(150, n);
    check("valid_period2", n, G);

    // Abort mid-gate: no publish, outputs hold
    tick(50);
    bus.en_i = 1'b0;
    tick(2);
    check("abort_busy", {31'd0, bus.busy_o}, 0);
    v0 = n_valid;
    tick(150);
    check("abort_no_valid", n_valid, v0);
    check("abort_hold_freq", {28'd0, bus.freq_o}, 10);

    // Restart: publish exactly G cycles after gate entry
    sb.push_back(exp_t'{freq: 4'd10, ovf: 1'b0});
    bus.en_i = 1'b1;
    tick(1);
    check("restart_busy", {31'd0, bus.busy_o}, 1);
    wait_valid(200, n);
    check("restart_latency", n, G);
    bus.en_i = 1'b0;
    tick(2);

    // Level high through reset and enable is never an edge
    gen_period = 0;
    gen_level  = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    check("reset_clears_freq", {28'd0, bus.freq_o}, 0);
    rst_n = 1'b1;
    tick(3);
    sb.push_back(exp_t'{freq: 4'd0, ovf: 1'b0});
    bus.en_i = 1'b1;
    wait_valid(150, n);
    bus.en_i = 1'b0;
    tick(2);

    // Boundary: a rise landing in the final cycle, then one cycle later
    gen_level = 1'b0;
    tick(5);
    sb.push_back(exp_t'{freq: 4'd1, ovf: 1'b0});
    sb.push_back(exp_t'{freq: 4'd0, ovf: 1'b0});
    sb.push_back(exp_t'{freq: 4'd1, ovf: 1'b0});
    bus.en_i = 1'b1;
    tick(1);
    check("boundary_busy", {31'd0, bus.busy_o}, 1);
    tick(97);
    gen_level = 1'b1;
    tick(53);
    gen_level = 1'b0;
    tick(48);
    gen_level = 1'b1;
    // Drop enable in the final cycle of the third gate: still published
    tick(101);
    bus.en_i = 1'b0;
    tick(3);
    check("tie_idle", {31'd0, bus.busy_o}, 0);
    tick(5);

    check("sb_empty", sb.size(), 0);
    check("valid_total", n_valid, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
